capture_controller: RTL and testbench
=====================================

# capture_controller

Sample-capture sequencer for the logic analyzer. Decimates the 8-bit probe bus, writes samples into the 8x128 distributed-RAM sample buffer as a circular buffer with a fixed pre-trigger window, detects the trigger, stops after the post-trigger window, then drives the buffer address for sequential readout. It sits directly upstream of the sample RAM and drives its write-enable, address and data inputs.

## Interface
- PRETRIG, 32: pre-trigger sample count. Legal range 1..126.
- RATE_W, 16: width of the sample-rate divider.

- in_clk  input  1  system clock
- in_rst  input  1  synchronous reset, active-high
- in_arm  input  1  start-capture pulse
- in_probe  input  8  probe bus, synchronous to in_clk
- in_trig_mask  input  8  trigger bit mask (1 = compare)
- in_trig_value  input  8  trigger compare value
- in_rate  input  RATE_W  divider: one sample every in_rate+1 clocks
- in_rd_next  input  1  advance readout address (READ state only)
- out_ram_we  output  1  RAM write enable
- out_ram_addr  output  7  RAM address
- out_ram_data  output  8  RAM write data
- out_state  output  3  IDLE=0, FILL=1, ARMED=2, POST=3, READ=4
- out_done  output  1  high while in READ
- out_start_addr  output  7  address of the oldest captured sample

## Operation
- All outputs are registered. Reset forces IDLE, all outputs 0, and all internal pointers and counters 0.
- in_arm is honored in IDLE and READ and ignored elsewhere. Arming clears wr_ptr, the divider and the fill count, clears out_done, and enters FILL.
- Divider: counts 0..in_rate and asserts the strobe at in_rate, then wraps to 0. in_rate=0 strobes every cycle. The divider runs only in FILL, ARMED and POST.
- Each strobe in FILL, ARMED or POST writes in_probe to wr_ptr. wr_ptr then increments mod 128 and wraps 127->0.
- FILL: counts writes. After the PRETRIG-th write, enter ARMED. The trigger is not evaluated in FILL.
- ARMED: on a strobe, the trigger matches when (in_probe & mask) == (value & mask). On a match, that sample is written at trig_addr = wr_ptr and the block enters POST with post_cnt = 127-PRETRIG. The buffer wraps indefinitely while waiting.
- POST: each strobe writes one sample and decrements post_cnt. The write at post_cnt=1 is the last. After it, enter READ and set out_start_addr = wr_ptr after the increment (= trig_addr-PRETRIG mod 128).
- A trigger at the first ARMED strobe is legal.
- mask=0 triggers on the first ARMED strobe.
- READ: out_ram_we=0, and out_ram_addr = rd_ptr, loaded with out_start_addr on entry. Each in_rd_next cycle increments rd_ptr mod 128. The 128th advance returns rd_ptr to out_start_addr.
- In IDLE, out_ram_addr holds 0 and out_ram_we is 0.
- A reset mid-capture aborts immediately into IDLE. RAM contents are not cleared.
- An in_arm coinciding with in_rd_next in READ: arm wins.

## Timing
- Strobe in cycle T samples in_probe. out_ram_we, out_ram_addr and out_ram_data are valid during T+1, and the RAM commits at the end of T+1.
- out_ram_we is a single-cycle pulse per strobe, so back-to-back pulses occur when in_rate=0.
- State transitions occur on the clock edge that ends the strobe cycle that causes them.
- out_done and out_state=READ rise in the same cycle as the final write pulse, T+1.
- READ: the RAM's registered output is valid one cycle after out_ram_addr changes, and only while out_ram_we=0.
- Arm latency: in_arm in cycle A puts out_state=FILL in A+1. The first strobe is at A+1+in_rate.

## Configuration
- CAPTURE_EDGE_TRIG_EN defined: the trigger fires only when the current strobed sample matches and the previous strobed sample did not.
  - The previous-match flag updates on every strobe in FILL and ARMED, and clears on arm.
  - A probe that already matches when ARMED is entered therefore waits for a non-match followed by a match.
- Undefined: level match as described in Operation, with no extra state.

## Test plan
- Reset: hold in_rst 3 cycles mid-POST -> out_state=0, out_ram_we=0, out_ram_addr=0, out_done=0, out_start_addr=0.
- Basic capture: PRETRIG=32, in_rate=0, probe = cycle counter, mask=8'hFF, value=8'h50 -> 128 write pulses total, trigger sample 8'h50 at trig_addr; out_start_addr = trig_addr-32; reading from start yields a contiguous increasing sequence with 8'h50 at position 32.
- Divider: in_rate=3 -> out_ram_we pulses exactly every 4 cycles; pulse count between arm and the FILL->ARMED transition = 32.
- Wrap: trigger delayed 300 samples -> wr_ptr wraps more than twice; captured window is still the 32 pre-trigger and 95 post-trigger samples around the trigger; address 127 is followed by 0.
- Readout: 128 in_rd_next pulses in READ -> addresses start..start+127 mod 128, returning to start; in_arm during READ -> FILL next cycle, out_done=0.
- Edge trigger (CAPTURE_EDGE_TRIG_EN): probe constant at a matching value 8'hA5 through ARMED -> no trigger; drive 8'h00 then 8'hA5 -> trigger on the 8'hA5 strobe. Same stimulus without the macro -> trigger on the first ARMED strobe.

Source files
------------

// File: rtl/capture_controller_if.sv
// Probe, trigger, readout and sample-RAM signals of capture_controller.
// master = stimulus / upstream side, slave = capture_controller.
interface capture_controller_if #(
    parameter int RATE_W = 16
);
    logic              in_arm;
    logic [7:0]        in_probe;
    logic [7:0]        in_trig_mask;
    logic [7:0]        in_trig_value;
    logic [RATE_W-1:0] in_rate;
    logic              in_rd_next;
    logic              out_ram_we;
    logic [6:0]        out_ram_addr;
    logic [7:0]        out_ram_data;
    logic [2:0]        out_state;
    logic              out_done;
    logic [6:0]        out_start_addr;

    modport master (
        output in_arm, in_probe, in_trig_mask, in_trig_value, in_rate, in_rd_next,
        input  out_ram_we, out_ram_addr, out_ram_data, out_state, out_done, out_start_addr
    );

    modport slave (
        input  in_arm, in_probe, in_trig_mask, in_trig_value, in_rate, in_rd_next,
        output out_ram_we, out_ram_addr, out_ram_data, out_state, out_done, out_start_addr
    );
endinterface

// File: rtl/capture_controller.sv
// Logic-analyzer capture sequencer: decimate, circular pre-trigger buffer, trigger, post window, readout.
// Define CAPTURE_EDGE_TRIG_EN for rising-match (edge) triggering instead of level matching.
module capture_controller #(
    parameter int PRETRIG = 32,
    parameter int RATE_W  = 16
) (
    input logic                 in_clk,
    input logic                 in_rst,
    capture_controller_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        READ  = 3'd4
    } state_t;

    localparam logic [6:0] LAST_FILL = 7'(PRETRIG - 1);
    localparam logic [6:0] POST_LEN  = 7'(127 - PRETRIG);

    state_t            state, state_d;
    logic [RATE_W-1:0] div_cnt;
    logic [6:0]        wr_ptr, rd_ptr, fill_cnt, post_cnt;
    logic              ram_we, done;
    logic [6:0]        ram_addr, start_addr;
    logic [7:0]        ram_data;
    logic              capturing, strobe, match, trig_hit, arm_go, last_post;

`ifdef CAPTURE_EDGE_TRIG_EN
    logic prev_match;
`endif

    always_comb begin
        capturing = (state == FILL) || (state == ARMED) || (state == POST);
        strobe    = capturing && (div_cnt == bus.in_rate);
        match     = ((bus.in_probe ^ bus.in_trig_value) & bus.in_trig_mask) == '0;
        arm_go    = bus.in_arm && ((state == IDLE) || (state == READ));
        last_post = strobe && (state == POST) && (post_cnt == 7'd1);
`ifdef CAPTURE_EDGE_TRIG_EN
        trig_hit  = strobe && (state == ARMED) && match && !prev_match;
`else
        trig_hit  = strobe && (state == ARMED) && match;
`endif
        state_d = state;
        case (state)
            IDLE:    if (arm_go) state_d = FILL;
            FILL:    if (strobe && (fill_cnt == LAST_FILL)) state_d = ARMED;
            ARMED:   if (trig_hit) state_d = POST;
            POST:    if (last_post) state_d = READ;
            READ:    if (arm_go) state_d = FILL;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            div_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            done       <= 1'b0;
            start_addr <= '0;
        end else begin
            ram_we <= 1'b0;
            if (arm_go) begin
                div_cnt  <= '0;
                wr_ptr   <= '0;
                fill_cnt <= '0;
                done     <= 1'b0;
                ram_addr <= '0;
            end else begin
                if (capturing)
                    div_cnt <= strobe ? '0 : div_cnt + 1'b1;
                if (strobe) begin
                    ram_we   <= 1'b1;
                    ram_addr <= wr_ptr;
                    ram_data <= bus.in_probe;
                    wr_ptr   <= wr_ptr + 7'd1;
                end
                if (strobe && (state == FILL))
                    fill_cnt <= fill_cnt + 7'd1;
                if (trig_hit)
                    post_cnt <= POST_LEN;
                if (strobe && (state == POST))
                    post_cnt <= post_cnt - 7'd1;
                // Oldest sample is the slot just after the final write.
                if (last_post) begin
                    done       <= 1'b1;
                    start_addr <= wr_ptr + 7'd1;
                    rd_ptr     <= wr_ptr + 7'd1;
                end
                // ram_addr mirrors rd_ptr's next value so both change on the same edge.
                if (state == READ) begin
                    if (bus.in_rd_next) rd_ptr <= rd_ptr + 7'd1;
                    ram_addr <= bus.in_rd_next ? rd_ptr + 7'd1 : rd_ptr;
                end
            end
        end
    end

`ifdef CAPTURE_EDGE_TRIG_EN
    always_ff @(posedge in_clk) begin
        if (in_rst || arm_go)
            prev_match <= 1'b0;
        else if (strobe && ((state == FILL) || (state == ARMED)))
            prev_match <= match;
    end
`endif

    assign bus.out_ram_we     = ram_we;
    assign bus.out_ram_addr   = ram_addr;
    assign bus.out_ram_data   = ram_data;
    assign bus.out_state      = state;
    assign bus.out_done       = done;
    assign bus.out_start_addr = start_addr;
endmodule

// File: tb/tb_capture_controller.sv
// Randomized scoreboard bench for capture_controller: expected write pulses are queued per capture
// from a sample-index model; a negedge monitor pops and compares every RAM write.
module tb_capture_controller;
    localparam int PRETRIG = 32;
    localparam int RATE_W  = 16;
    localparam int MAXS    = 600;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    capture_controller_if #(.RATE_W(RATE_W)) bus ();

    capture_controller #(.PRETRIG(PRETRIG), .RATE_W(RATE_W)) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus)
    );

    typedef struct {
        int unsigned cyc;
        logic [6:0]  addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] shadow [128];
    logic [7:0] sample [MAXS];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         trigk, nwr, win_base;
    logic [6:0] exp_start;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit hit(input logic [7:0] s, input logic [7:0] m, input logic [7:0] v);
        return ((s ^ v) & m) == 8'h00;
    endfunction

    // First sample index (past the pre-trigger fill) that satisfies the trigger rule.
    function automatic int find_trig(input logic [7:0] m, input logic [7:0] v);
        for (int k = PRETRIG; k < MAXS - 128; k++) begin
`ifdef CAPTURE_EDGE_TRIG_EN
            if (hit(sample[k], m, v) && !hit(sample[k-1], m, v)) return k;
`else
            if (hit(sample[k], m, v)) return k;
`endif
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (bus.out_ram_we === 1'b1) begin
            shadow[bus.out_ram_addr] = bus.out_ram_data;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got write addr %0d data %0d at cycle %0d, required no write",
                         bus.out_ram_addr, bus.out_ram_data, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_cycle", cyc, e.cyc);
                check("write_addr", bus.out_ram_addr, e.addr);
                check("write_data", bus.out_ram_data, e.data);
            end
        end
    end

    task automatic fill_random();
        for (int k = 0; k < MAXS; k++) sample[k] = 8'($urandom);
    endtask

    task automatic run_capture(input int rate, input logic [7:0] m, input logic [7:0] v,
                               input bit with_rd_next, input bit poke_arm, input int abort_k);
        int unsigned a;
        trigk = find_trig(m, v);
        if (trigk < 0) begin
            sample[MAXS-130] = v ^ m;
            sample[MAXS-129] = v;
            trigk = find_trig(m, v);
        end
        nwr       = trigk + 128 - PRETRIG;
        win_base  = trigk - PRETRIG;
        exp_start = 7'(win_base % 128);

        bus.in_trig_mask  = m;
        bus.in_trig_value = v;
        bus.in_rate       = RATE_W'(rate);
        bus.in_arm        = 1'b1;
        bus.in_rd_next    = with_rd_next;
        a = cyc;
        for (int k = 0; k < nwr; k++)
            exp_q.push_back('{a + 2 + rate + k * (rate + 1), 7'(k % 128), sample[k]});
        tick();
        bus.in_arm     = 1'b0;
        bus.in_rd_next = 1'b0;
        check("arm_state", bus.out_state, 1);
        check("arm_done", bus.out_done, 0);

        for (int k = 0; k < nwr; k++) begin
            for (int j = 0; j <= rate; j++) begin
                bus.in_probe = (j == rate) ? sample[k] : 8'($urandom);
                bus.in_arm   = poke_arm && (k == PRETRIG + 2) && (j == 0) && (trigk > PRETRIG + 2);
                tick();
            end
            bus.in_arm = 1'b0;
            if (k == PRETRIG - 1) check("fill_to_armed", bus.out_state, 2);
            if (k == trigk && k < nwr - 1) check("armed_to_post", bus.out_state, 3);
            if (k == abort_k) begin
                rst = 1'b1;
                repeat (3) tick();
                check("abort_state", bus.out_state, 0);
                check("abort_we", bus.out_ram_we, 0);
                check("abort_addr", bus.out_ram_addr, 0);
                check("abort_done", bus.out_done, 0);
                check("abort_start", bus.out_start_addr, 0);
                rst = 1'b0;
                exp_q.delete();
                tick();
                check("abort_idle", bus.out_state, 0);
                return;
            end
        end
        check("final_state", bus.out_state, 4);
        check("final_done", bus.out_done, 1);
        check("final_we", bus.out_ram_we, 1);
        check("start_addr", bus.out_start_addr, exp_start);
        tick();
        check("pending_writes", exp_q.size(), 0);
    endtask

    task automatic readout();
        check("read_addr0", bus.out_ram_addr, exp_start);
        check("read_we", bus.out_ram_we, 0);
        check("read_data0", shadow[bus.out_ram_addr], sample[win_base]);
        for (int i = 1; i <= 128; i++) begin
            bus.in_rd_next = 1'b1;
            tick();
            check("read_addr", bus.out_ram_addr, (exp_start + i) % 128);
            check("read_data", shadow[bus.out_ram_addr], sample[win_base + (i % 128)]);
        end
        bus.in_rd_next = 1'b0;
        tick();
        check("read_hold", bus.out_ram_addr, exp_start);
        check("read_state", bus.out_state, 4);
    endtask

    initial begin
        logic [7:0] m;
        rst               = 1'b1;
        bus.in_arm        = 1'b0;
        bus.in_probe      = '0;
        bus.in_trig_mask  = '0;
        bus.in_trig_value = '0;
        bus.in_rate       = '0;
        bus.in_rd_next    = 1'b0;
        repeat (3) tick();
        check("rst_state", bus.out_state, 0);
        check("rst_we", bus.out_ram_we, 0);
        check("rst_addr", bus.out_ram_addr, 0);
        check("rst_done", bus.out_done, 0);
        check("rst_start", bus.out_start_addr, 0);
        rst = 1'b0;
        tick();
        check("idle_addr", bus.out_ram_addr, 0);

        // Counting probe, trigger on 8'h50.
        for (int k = 0; k < MAXS; k++) sample[k] = 8'(k);
        run_capture(0, 8'hFF, 8'h50, 1'b0, 1'b0, -1);
        readout();

        // Divider 3, random trigger; arm from READ alongside rd_next.
        fill_random();
        m = 8'($urandom_range(1, 255));
        run_capture(3, m, 8'($urandom), 1'b1, 1'b0, -1);
        readout();

        // Trigger delayed 300 samples; stray arm while ARMED.
        fill_random();
        for (int k = 0; k < PRETRIG + 300; k++) if (sample[k] == 8'hC3) sample[k] = 8'hC2;
        sample[PRETRIG + 300] = 8'hC3;
        run_capture(1, 8'hFF, 8'hC3, 1'b0, 1'b1, -1);
        readout();

        // Probe already matching through ARMED, then 00, then A5.
        fill_random();
        for (int k = 0; k < PRETRIG + 10; k++) sample[k] = 8'hA5;
        sample[PRETRIG + 10] = 8'h00;
        sample[PRETRIG + 11] = 8'hA5;
        run_capture(0, 8'hFF, 8'hA5, 1'b0, 1'b0, -1);
        readout();

`ifndef CAPTURE_EDGE_TRIG_EN
        fill_random();
        run_capture(2, 8'h00, 8'($urandom), 1'b0, 1'b0, -1);
        readout();
`endif

        // Reset mid-POST.
        for (int k = 0; k < MAXS; k++) sample[k] = 8'(k);
        run_capture(1, 8'hFF, 8'h40, 1'b0, 1'b0, 64 + 20);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            m = 8'($urandom_range(1, 255));
            run_capture($urandom_range(0, 4), m, 8'($urandom), 1'b0, 1'b1, -1);
            readout();
        end

        repeat (2) tick();
        check("no_stray_writes", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
